// File: rtl/traffic_gen_sched.sv
// Job scheduler for the traffic_gen kernel: queues traffic profiles, launches them one at a time, watchdogs each run.
// Optional per-job RUN cycle counter enabled by TRAFFIC_GEN_SCHED_PERF_EN.
module traffic_gen_sched #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned N_JOBS     = 4,
    parameter int unsigned TO_WIDTH   = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [WORD_WIDTH-1:0] job_n_total_reqs_i,
    input  logic [WORD_WIDTH-1:0] job_t_ck_reqs_i,
    input  logic [WORD_WIDTH-1:0] job_t_ck_idle_i,
    input  logic [TO_WIDTH-1:0]   timeout_i,
    input  logic                  clear_i,
    output logic [WORD_WIDTH-1:0] n_total_reqs_o,
    output logic [WORD_WIDTH-1:0] t_ck_reqs_o,
    output logic [WORD_WIDTH-1:0] t_ck_idle_o,
    output logic                  ap_start_o,
    input  logic                  ap_done_i,
    output logic                  busy_o,
    output logic                  evt_o,
    output logic [WORD_WIDTH-1:0] jobs_done_o,
    output logic                  err_timeout_o,
    output logic                  err_cfg_o,
    output logic [WORD_WIDTH-1:0] last_job_cycles_o
);

    localparam int unsigned PTR_W = (N_JOBS > 1) ? $clog2(N_JOBS) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] n_total_reqs;
        logic [WORD_WIDTH-1:0] t_ck_reqs;
        logic [WORD_WIDTH-1:0] t_ck_idle;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    job_t                fifo_q [N_JOBS];
    job_t                head;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full_q;
    logic                fifo_empty;
    logic                push, pop, load, cfg_err_set, job_bad;
    logic [TO_WIDTH-1:0] wd_q;
    logic [WORD_WIDTH-1:0] n_total_reqs_q, t_ck_reqs_q, t_ck_idle_q, jobs_done_q;
    logic                ap_start_q, busy_q, evt_q, err_timeout_q, err_cfg_q;

    assign head        = fifo_q[rd_ptr_q];
    assign fifo_empty  = (cnt_q == '0);
    assign push        = job_valid_i & ~full_q & ~clear_i;
    assign job_bad     = (head.n_total_reqs < WORD_WIDTH'(2)) || (head.t_ck_reqs == '0);

    // Next-state and per-cycle strobes; clear_i overrides every transition.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load        = 1'b0;
        cfg_err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop = 1'b1;
                if (job_bad) begin
                    cfg_err_set = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ap_done_i) begin
                    state_d = S_DONE;
                end else if ((timeout_i != '0) && (wd_q == TO_WIDTH'(timeout_i - TO_WIDTH'(1)))) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = fifo_empty ? S_IDLE : S_LOAD;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d     = S_IDLE;
            pop         = 1'b0;
            load        = 1'b0;
            cfg_err_set = 1'b0;
        end
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) cnt_d = '0;
    end

    always_ff @(posedge ap_clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{job_n_total_reqs_i, job_t_ck_reqs_i, job_t_ck_idle_i};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(N_JOBS));
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Kernel config, watchdog, status and error registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            n_total_reqs_q <= '0;
            t_ck_reqs_q    <= '0;
            t_ck_idle_q    <= '0;
            wd_q           <= '0;
            ap_start_q     <= 1'b0;
            busy_q         <= 1'b0;
            evt_q          <= 1'b0;
            jobs_done_q    <= '0;
            err_timeout_q  <= 1'b0;
            err_cfg_q      <= 1'b0;
        end else begin
            if (load) begin
                n_total_reqs_q <= head.n_total_reqs;
                t_ck_reqs_q    <= head.t_ck_reqs;
                t_ck_idle_q    <= head.t_ck_idle;
            end
            if (clear_i || load)     wd_q <= '0;
            else if (state_q == S_RUN) wd_q <= wd_q + TO_WIDTH'(1);
            ap_start_q <= (state_d == S_RUN);
            busy_q     <= (state_d != S_IDLE) || (cnt_d != '0);
            evt_q      <= (state_d == S_DONE);
            if (state_d == S_DONE) jobs_done_q <= jobs_done_q + WORD_WIDTH'(1);
            if (clear_i) begin
                err_timeout_q <= 1'b0;
                err_cfg_q     <= 1'b0;
            end else begin
                if ((state_q == S_RUN) && (state_d == S_ERR)) err_timeout_q <= 1'b1;
                if (cfg_err_set) err_cfg_q <= 1'b1;
            end
        end
    end

`ifdef TRAFFIC_GEN_SCHED_PERF_EN
    logic [WORD_WIDTH-1:0] run_cyc_q, run_cyc_inc, last_cyc_q;

    assign run_cyc_inc = (&run_cyc_q) ? run_cyc_q : run_cyc_q + WORD_WIDTH'(1);

    // Saturating RUN-cycle counter; the captured value includes the completing cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run_cyc_q  <= '0;
            last_cyc_q <= '0;
        end else begin
            if (load)                   run_cyc_q <= '0;
            else if (state_q == S_RUN)  run_cyc_q <= run_cyc_inc;
            if ((state_q == S_RUN) && (state_d == S_DONE)) last_cyc_q <= run_cyc_inc;
        end
    end

    assign last_job_cycles_o = last_cyc_q;
`else
    assign last_job_cycles_o = '0;
`endif

    assign job_ready_o    = ~full_q;
    assign n_total_reqs_o = n_total_reqs_q;
    assign t_ck_reqs_o    = t_ck_reqs_q;
    assign t_ck_idle_o    = t_ck_idle_q;
    assign ap_start_o     = ap_start_q;
    assign busy_o         = busy_q;
    assign evt_o          = evt_q;
    assign jobs_done_o    = jobs_done_q;
    assign err_timeout_o  = err_timeout_q;
    assign err_cfg_o      = err_cfg_q;

endmodule
